// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// conv_pkg: shared types for the 5x5 convolution kernel MAC datapath.
// Revision: 1.0
// ============================================================================
package conv_pkg;

  localparam int KSIZE    = 5;
  localparam int KERNEL_N = KSIZE * KSIZE;
  localparam int PIXEL_W  = 8;
  localparam int COEFF_W  = 8;
  localparam int PROD_W   = PIXEL_W + COEFF_W + 1;
  localparam int ACC_W    = PROD_W + 5;

  typedef logic [PIXEL_W-1:0]        pixel_t;
  typedef pixel_t [KERNEL_N-1:0]     kernel_t;
  typedef logic signed [COEFF_W-1:0] coeff_t;
  typedef coeff_t [KERNEL_N-1:0]     coeff_kernel_t;
  typedef logic signed [PROD_W-1:0]  prod_t;
  typedef logic signed [ACC_W-1:0]   acc_t;

  typedef struct packed {
    logic sof;
    logic eol;
  } pos_tag_t;

  localparam acc_t ACC_PIXEL_MAX = acc_t'(2**PIXEL_W - 1);

  function automatic logic is_clamped(input acc_t v);
    return v[ACC_W-1] || (v > ACC_PIXEL_MAX);
  endfunction

  function automatic pixel_t sat_pixel(input acc_t v);
    if (v[ACC_W-1]) begin
      return '0;
    end else if (v > ACC_PIXEL_MAX) begin
      return '1;
    end
    return v[PIXEL_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_kernel_mac_round.sv
`default_nettype none
// ============================================================================
// conv_kernel_mac_round: combinational round-half-up, arithmetic shift and
// saturation of an accumulator to one pixel. The parent registers the result.
// Revision: 1.0
// ============================================================================
module conv_kernel_mac_round
  import conv_pkg::*;
#(
  parameter int SHIFT = 4
) (
  input  acc_t   acc_i,
  output pixel_t pix_o,
  output logic   sat_o
);

  acc_t rounded;
  acc_t shifted;

  generate
    if (SHIFT > 0) begin : g_round
      assign rounded = acc_i + acc_t'(1 << (SHIFT - 1));
    end else begin : g_no_round
      assign rounded = acc_i;
    end
  endgenerate

  assign shifted = rounded >>> SHIFT;
  assign pix_o   = sat_pixel(shifted);
  assign sat_o   = is_clamped(shifted);

endmodule
`default_nettype wire

// File: rtl/conv_kernel_mac.sv
`default_nettype none
// ============================================================================
// conv_kernel_mac: 5x5 kernel multiply-accumulate with round/shift/saturate
// and regenerated SOF/EOL tags. Optional saturation counter: CONV_KERNEL_MAC_STATS_EN.
// Revision: 1.0
// ============================================================================
module conv_kernel_mac
  import conv_pkg::*;
#(
  parameter int IMG_W   = 16,
  parameter int IMG_H   = 8,
  parameter int COEFF_W = 8,
  parameter int SHIFT   = 4
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          s_tvalid_i,
  input  kernel_t       s_tdata_i,
  input  logic          s_tuser_i,
  input  logic          s_tlast_i,
  output logic          s_tready_o,
  input  coeff_kernel_t coeff_i,
  input  logic          m_tready_i,
  output logic          m_tvalid_o,
  output pixel_t        m_tdata_o,
  output logic          m_tuser_o,
`ifdef CONV_KERNEL_MAC_STATS_EN
  output logic [15:0]   sat_cnt_o,
`endif
  output logic          m_tlast_o
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  generate
    if (COEFF_W != conv_pkg::COEFF_W || SHIFT < 0 || SHIFT > 15) begin : g_param_err
      $error("conv_kernel_mac: COEFF_W must match conv_pkg and SHIFT must be 0..15");
    end
  endgenerate

  logic en;
  logic accept;

  // One enable for every stage; the input side has no skid buffer.
  assign en         = !m_tvalid_o || m_tready_i;
  assign s_tready_o = en;
  assign accept     = s_tvalid_i && en;

  logic [COL_W-1:0] col_q, col_d, base_col;
  logic [ROW_W-1:0] row_q, row_d, base_row;
  pos_tag_t         tag_d;

  always_comb begin
    base_col  = s_tuser_i ? '0 : col_q;
    base_row  = s_tuser_i ? '0 : row_q;
    tag_d.sof = (base_col == '0) && (base_row == '0);
    tag_d.eol = (base_col == COL_LAST);
    if (base_col == COL_LAST) begin
      col_d = '0;
      row_d = (base_row == ROW_LAST) ? '0 : base_row + ROW_W'(1);
    end else begin
      col_d = base_col + COL_W'(1);
      row_d = base_row;
    end
  end

  prod_t    prod_d   [KERNEL_N];
  prod_t    prod_q   [KERNEL_N];
  acc_t     rowsum_d [KSIZE];
  acc_t     rowsum_q [KSIZE];
  acc_t     sum_d;
  logic     v1_q, v2_q;
  pos_tag_t tag1_q, tag2_q;
  pixel_t   pix_d;
  logic     sat_d;

  // Pixels are unsigned, so a zero MSB keeps them positive in the signed multiply.
  always_comb begin
    for (int i = 0; i < KERNEL_N; i++) begin
      prod_d[i] = prod_t'($signed({1'b0, s_tdata_i[i]})) * prod_t'($signed(coeff_i[i]));
    end
  end

  always_comb begin
    for (int r = 0; r < KSIZE; r++) begin
      rowsum_d[r] = '0;
      for (int c = 0; c < KSIZE; c++) begin
        rowsum_d[r] = rowsum_d[r] + acc_t'(prod_q[r*KSIZE+c]);
      end
    end
  end

  always_comb begin
    sum_d = '0;
    for (int r = 0; r < KSIZE; r++) begin
      sum_d = sum_d + rowsum_q[r];
    end
  end

  conv_kernel_mac_round #(
    .SHIFT (SHIFT)
  ) u_round (
    .acc_i (sum_d),
    .pix_o (pix_d),
    .sat_o (sat_d)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      col_q      <= '0;
      row_q      <= '0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      tag1_q     <= '0;
      tag2_q     <= '0;
      m_tvalid_o <= 1'b0;
      m_tdata_o  <= '0;
      m_tuser_o  <= 1'b0;
      m_tlast_o  <= 1'b0;
      for (int i = 0; i < KERNEL_N; i++) prod_q[i] <= '0;
      for (int r = 0; r < KSIZE; r++) rowsum_q[r] <= '0;
    end else if (en) begin
      if (accept) begin
        col_q <= col_d;
        row_q <= row_d;
      end
      v1_q   <= s_tvalid_i;
      tag1_q <= tag_d;
      prod_q <= prod_d;
      v2_q     <= v1_q;
      tag2_q   <= tag1_q;
      rowsum_q <= rowsum_d;
      m_tvalid_o <= v2_q;
      if (v2_q) begin
        m_tdata_o <= pix_d;
        m_tuser_o <= tag2_q.sof;
        m_tlast_o <= tag2_q.eol;
      end
    end
  end

`ifdef CONV_KERNEL_MAC_STATS_EN
  logic [15:0] sat_cnt_q;

  // A frame's first beat restarts the count and is itself counted.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sat_cnt_q <= '0;
    end else if (en && v2_q) begin
      if (tag2_q.sof) begin
        sat_cnt_q <= {15'd0, sat_d};
      end else if (sat_d && (sat_cnt_q != 16'hFFFF)) begin
        sat_cnt_q <= sat_cnt_q + 16'd1;
      end
    end
  end

  assign sat_cnt_o = sat_cnt_q;

  logic unused_ok;
  assign unused_ok = s_tlast_i;
`else
  logic unused_ok;
  assign unused_ok = ^{s_tlast_i, sat_d};
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_kernel_mac.sv
`default_nettype none
// ============================================================================
// tb_conv_kernel_mac: randomized self-checking bench for conv_kernel_mac,
// three instances (SHIFT 4, 1, 0) against a plain-arithmetic reference model.
// Revision: 1.0
// ============================================================================
module tb_conv_kernel_mac;
  import conv_pkg::*;

  typedef struct packed {
    logic [7:0] d4;
    logic [7:0] d1;
    logic [7:0] d0;
    logic       sof;
    logic       eol;
  } beat_t;

  typedef struct packed {
    logic       rdy;
    logic       vld;
    logic [7:0] d;
    logic       sof;
    logic       eol;
  } snap_t;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          s_tvalid_i = 1'b0;
  kernel_t       s_tdata_i = '0;
  logic          s_tuser_i = 1'b0;
  logic          s_tlast_i = 1'b0;
  coeff_kernel_t coeff = '0;
  logic          m_tready_i = 1'b1;
  logic          s_tready_o, m_tvalid_o, m_tuser_o, m_tlast_o;
  pixel_t        m_tdata_o;
  logic          rdy1, vld1, tu1, tl1, rdy0, vld0, tu0, tl0;
  pixel_t        d1, d0;
`ifdef CONV_KERNEL_MAC_STATS_EN
  logic [15:0]   sat4, sat1, sat0;
`endif

  always #5 clk = ~clk;

  conv_kernel_mac #(.IMG_W(16), .IMG_H(8), .COEFF_W(8), .SHIFT(4)) u_dut4 (
    .clk(clk), .arst_n(arst_n), .s_tvalid_i(s_tvalid_i), .s_tdata_i(s_tdata_i),
    .s_tuser_i(s_tuser_i), .s_tlast_i(s_tlast_i), .s_tready_o(s_tready_o), .coeff_i(coeff),
    .m_tready_i(m_tready_i), .m_tvalid_o(m_tvalid_o), .m_tdata_o(m_tdata_o), .m_tuser_o(m_tuser_o),
`ifdef CONV_KERNEL_MAC_STATS_EN
    .sat_cnt_o(sat4),
`endif
    .m_tlast_o(m_tlast_o));

  conv_kernel_mac #(.IMG_W(16), .IMG_H(8), .COEFF_W(8), .SHIFT(1)) u_dut1 (
    .clk(clk), .arst_n(arst_n), .s_tvalid_i(s_tvalid_i), .s_tdata_i(s_tdata_i),
    .s_tuser_i(s_tuser_i), .s_tlast_i(s_tlast_i), .s_tready_o(rdy1), .coeff_i(coeff),
    .m_tready_i(m_tready_i), .m_tvalid_o(vld1), .m_tdata_o(d1), .m_tuser_o(tu1),
`ifdef CONV_KERNEL_MAC_STATS_EN
    .sat_cnt_o(sat1),
`endif
    .m_tlast_o(tl1));

  conv_kernel_mac #(.IMG_W(16), .IMG_H(8), .COEFF_W(8), .SHIFT(0)) u_dut0 (
    .clk(clk), .arst_n(arst_n), .s_tvalid_i(s_tvalid_i), .s_tdata_i(s_tdata_i),
    .s_tuser_i(s_tuser_i), .s_tlast_i(s_tlast_i), .s_tready_o(rdy0), .coeff_i(coeff),
    .m_tready_i(m_tready_i), .m_tvalid_o(vld0), .m_tdata_o(d0), .m_tuser_o(tu0),
`ifdef CONV_KERNEL_MAC_STATS_EN
    .sat_cnt_o(sat0),
`endif
    .m_tlast_o(tl0));

  int      errors = 0;
  int      checks = 0;
  int      cyc = 0;
  int      mcol = 0, mrow = 0, mstat = 0;
  kernel_t kq[$];
  bit      tuq[$];
  beat_t   exp_q[$], obs_q[$];
  int      acc_cyc[$], obs_cyc[$];
  snap_t   snap_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Output collector: records every transfer with the cycle it was seen in.
  always @(negedge clk) begin
    if (arst_n && m_tvalid_o && m_tready_i) begin
      obs_q.push_back({m_tdata_o, d1, d0, m_tuser_o, m_tlast_o});
      obs_cyc.push_back(cyc);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
    $fatal(1);
  end

  function automatic int rnd_shift(input int sum, input int sh);
    if (sh == 0) return sum;
    return (sum + (1 << (sh - 1))) >>> sh;
  endfunction

  function automatic logic [7:0] clamp8(input int v);
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return 8'(v);
  endfunction

  function automatic kernel_t rand_kernel();
    kernel_t k;
    for (int i = 0; i < 25; i++) k[i] = 8'($urandom_range(0, 255));
    return k;
  endfunction

  task automatic add_beat(input kernel_t k, input bit tu);
    int    sum;
    int    v4;
    beat_t b;
    sum = 0;
    for (int i = 0; i < 25; i++) sum += int'(k[i]) * int'($signed(coeff[i]));
    if (tu) begin
      mcol = 0;
      mrow = 0;
    end
    b.sof = (mcol == 0) && (mrow == 0);
    b.eol = (mcol == 15);
    mcol++;
    if (mcol == 16) begin
      mcol = 0;
      mrow = (mrow + 1) % 8;
    end
    v4   = rnd_shift(sum, 4);
    b.d4 = clamp8(v4);
    b.d1 = clamp8(rnd_shift(sum, 1));
    b.d0 = clamp8(sum);
    if (b.sof) mstat = 0;
    if ((v4 < 0 || v4 > 255) && mstat < 65535) mstat++;
    exp_q.push_back(b);
    kq.push_back(k);
    tuq.push_back(tu);
  endtask

  task automatic clear_all();
    kq.delete(); tuq.delete(); exp_q.delete(); obs_q.delete();
    acc_cyc.delete(); obs_cyc.delete(); snap_q.delete();
  endtask

  task automatic do_reset();
    arst_n = 1'b0; s_tvalid_i = 1'b0; s_tuser_i = 1'b0; m_tready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 arst_n = 1'b1;
    mcol = 0; mrow = 0; mstat = 0;
    clear_all();
  endtask

  // Drives the queued beats; m_tready_i is low during cycles [st, st+len).
  task automatic run_stream(input int st, input int len);
    int idx = 0, k = 0, budget = 0;
    bit acc, stall;
    while (idx < kq.size() && k < 5000) begin
      stall = (k >= st) && (k < st + len);
      s_tvalid_i = 1'b1; s_tdata_i = kq[idx]; s_tuser_i = tuq[idx]; m_tready_i = !stall;
      @(negedge clk);
      acc = s_tready_o;
      if (stall) snap_q.push_back({s_tready_o, m_tvalid_o, m_tdata_o, m_tuser_o, m_tlast_o});
      if (acc) acc_cyc.push_back(cyc);
      @(posedge clk); #1;
      if (acc) idx++;
      k++;
    end
    s_tvalid_i = 1'b0; s_tuser_i = 1'b0; m_tready_i = 1'b1;
    while (obs_q.size() < exp_q.size() && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (m_tvalid_o !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", m_tvalid_o); end
    checks++; if (m_tdata_o !== 8'd0) begin errors++; $display("FAIL reset_tdata: got %h expected 00", m_tdata_o); end
    checks++; if ({m_tuser_o, m_tlast_o} !== 2'b00) begin errors++; $display("FAIL reset_tags: got %b expected 00", {m_tuser_o, m_tlast_o}); end
    checks++; if (s_tready_o !== 1'b1) begin errors++; $display("FAIL reset_tready: got %b expected 1", s_tready_o); end
    @(posedge clk);
    #1 arst_n = 1'b1;
  endtask

  task automatic test_identity();
    kernel_t k;
    clear_all();
    coeff = '0; coeff[12] = coeff_t'(16);
    for (int i = 0; i < 128; i++) begin
      k = rand_kernel();
      k[12] = 8'(i % 256);
      add_beat(k, 1'b0);
    end
    run_stream(-1, 0);
    checks++;
    if (obs_q.size() != exp_q.size() || acc_cyc.size() != exp_q.size()) begin
      errors++; $display("FAIL identity_count: got %0d outputs expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i] || obs_q[i].d4 !== 8'(i)) begin
        errors++; $display("FAIL identity_beat %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    for (int i = 0; i < acc_cyc.size() && i < obs_cyc.size(); i++) begin
      checks++;
      if (obs_cyc[i] - acc_cyc[i] != 3 || acc_cyc[i] != acc_cyc[0] + i) begin
        errors++; $display("FAIL identity_timing %0d: got latency %0d expected 3 (accept cycle %0d)", i, obs_cyc[i] - acc_cyc[i], acc_cyc[i]);
      end
    end
  endtask

  task automatic test_saturate();
    kernel_t k;
    for (int p = 0; p < 3; p++) begin
      clear_all();
      coeff = '0;
      for (int n = 0; n < 4; n++) begin
        k = rand_kernel();
        case (p)
          0: begin for (int i = 0; i < 25; i++) begin coeff[i] = coeff_t'(1); k[i] = 8'd255; end end
          1: begin coeff[12] = coeff_t'(-16); k[12] = 8'd100; end
          default: begin coeff[12] = coeff_t'(3); k[12] = 8'd5; end
        endcase
        add_beat(k, 1'b0);
      end
      run_stream(-1, 0);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++; $display("FAIL saturate_count phase %0d: got %0d expected %0d", p, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL saturate_beat phase %0d beat %0d: got %h expected %h", p, i, obs_q[i], exp_q[i]);
        end
      end
      if (obs_q.size() > 0) begin
        checks++;
        if ({obs_q[0].d4, obs_q[0].d1, obs_q[0].d0} !== (p == 0 ? 24'hFFFFFF : p == 1 ? 24'h000000 : 24'h01080F)) begin
          errors++; $display("FAIL saturate_value phase %0d: got %h", p, {obs_q[0].d4, obs_q[0].d1, obs_q[0].d0});
        end
      end
`ifdef CONV_KERNEL_MAC_STATS_EN
      checks++;
      if (sat4 !== 16'(mstat)) begin errors++; $display("FAIL sat_cnt phase %0d: got %0d expected %0d", p, sat4, mstat); end
`endif
    end
  endtask

  task automatic test_backpressure();
    clear_all();
    for (int i = 0; i < 25; i++) coeff[i] = coeff_t'($urandom_range(0, 255));
    for (int n = 0; n < 60; n++) add_beat(rand_kernel(), 1'b0);
    run_stream(20, 5);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL backpressure_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL backpressure_beat %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (snap_q.size() != 5) begin
      errors++; $display("FAIL stall_snapshots: got %0d expected 5", snap_q.size());
    end
    for (int j = 0; j < snap_q.size(); j++) begin
      checks++;
      if (snap_q[j].rdy !== 1'b0 || snap_q[j].vld !== 1'b1 ||
          {snap_q[j].d, snap_q[j].sof, snap_q[j].eol} !== {snap_q[0].d, snap_q[0].sof, snap_q[0].eol}) begin
        errors++; $display("FAIL stall_hold %0d: got %h expected rdy=0 vld=1 data held %h", j, snap_q[j], snap_q[0]);
      end
    end
`ifdef CONV_KERNEL_MAC_STATS_EN
    checks++;
    if (sat4 !== 16'(mstat)) begin errors++; $display("FAIL sat_cnt_bp: got %0d expected %0d", sat4, mstat); end
`endif
  endtask

  task automatic test_framing();
    int bad;
    do_reset();
    coeff = '0; coeff[12] = coeff_t'(16);
    for (int run = 0; run < 2; run++) begin
      clear_all();
      for (int n = 0; n < (run == 0 ? 256 : 200); n++) add_beat(rand_kernel(), (run == 1) && (n == 40));
      run_stream(-1, 0);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++; $display("FAIL framing_count run %0d: got %0d expected %0d", run, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL framing_beat run %0d beat %0d: got %h expected %h", run, i, obs_q[i], exp_q[i]);
        end
      end
      bad = 0;
      if (run == 0) begin
        for (int i = 0; i < obs_q.size(); i++)
          if (obs_q[i].sof !== (i % 128 == 0) || obs_q[i].eol !== (i % 16 == 15)) bad++;
        if (obs_q.size() != 256) bad++;
      end else begin
        if (obs_q.size() < 169) bad++;
        else if ({obs_q[40].sof, obs_q[55].eol, obs_q[168].sof, obs_q[41].sof} !== 4'b1110) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL framing_positions run %0d: got %0d bad tags expected 0", run, bad); end
    end
  endtask

  task automatic test_reset_midflight();
    clear_all();
    coeff = '0; coeff[12] = coeff_t'(16);
    for (int n = 0; n < 5; n++) add_beat(rand_kernel(), 1'b0);
    run_stream(-1, 0);
    for (int i = 0; i < 4; i++) begin
      s_tvalid_i = 1'b1; s_tdata_i = rand_kernel();
      @(posedge clk); #1;
    end
    checks++;
    if (m_tvalid_o !== 1'b1) begin errors++; $display("FAIL midflight_pre: got tvalid %b expected 1", m_tvalid_o); end
    arst_n = 1'b0; s_tvalid_i = 1'b0;
    #1;
    checks++;
    if (m_tvalid_o !== 1'b0 || m_tdata_o !== 8'd0) begin
      errors++; $display("FAIL midflight_async: got tvalid %b data %h expected 0 00", m_tvalid_o, m_tdata_o);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (m_tvalid_o !== 1'b0) begin errors++; $display("FAIL midflight_hold: got tvalid %b expected 0", m_tvalid_o); end
    arst_n = 1'b1;
    mcol = 0; mrow = 0; mstat = 0;
    clear_all();
    for (int n = 0; n < 3; n++) add_beat(rand_kernel(), 1'b0);
    run_stream(-1, 0);
    checks++;
    if (obs_q.size() != 3 || obs_q[0].sof !== 1'b1) begin
      errors++; $display("FAIL midflight_sof: got %0d outputs first sof %b expected 3 outputs sof 1", obs_q.size(), obs_q.size() > 0 ? obs_q[0].sof : 1'bx);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL midflight_beat %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_saturate();
    test_backpressure();
    test_framing();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv_kernel_mac.md
Name: conv_kernel_mac

Overview:
- Downstream consumer of the convolution window stream: accepts one 5x5 pixel kernel per beat on an AXI-stream-style slave interface.
- Computes a weighted sum against a 5x5 signed coefficient set, then rounds, shifts and saturates to one output pixel.
- Emits output pixels on an AXI-stream master with regenerated start-of-frame (tuser) and end-of-line (tlast).
- Completes the filter datapath after the window generator.

Parameters:
- IMG_W, 16, image width in pixels; sets the tlast position.
- IMG_H, 8, image height in lines; sets the frame wrap.
- COEFF_W, 8, signed coefficient width.
- SHIFT, 4, right-shift applied after accumulation, range 0..15.

Ports:
- clk  in  1  clock
- arst_n  in  1  asynchronous active-low reset
- s_tvalid_i  in  1  kernel beat valid
- s_tdata_i  in  conv_pkg::kernel_t  25 pixels; index r*5+c, where (2,2) is the centre
- s_tuser_i  in  1  optional SOF hint; 1 resyncs the position counters
- s_tlast_i  in  1  ignored
- s_tready_o  out  1  beat accepted when s_tvalid_i && s_tready_o
- coeff_i  in  conv_pkg::coeff_kernel_t  25 signed coefficients; quasi-static, change only while the block is idle
- m_tready_i  in  1  downstream ready
- m_tvalid_o  out  1  output pixel valid
- m_tdata_o  out  conv_pkg::pixel_t  filtered pixel
- m_tuser_o  out  1  first pixel of frame
- m_tlast_o  out  1  last pixel of line

Behaviour:
- Reset: all stage valids = 0; m_tvalid_o = 0; m_tdata_o, m_tuser_o and m_tlast_o = 0; col and row counters = 0.
- Pipeline: 3 stages, with one global enable en = !m_tvalid_o || m_tready_i.
- s_tready_o = en. This is a combinational path from m_tready_i; no skid buffer.
- S1: register 25 products pixel (unsigned, zero-extended) x coeff (signed). Product width is PIXEL_W+COEFF_W+1.
- S2: register 5 row sums.
- S3: final sum into acc_t (product width + 5 bits).
- Round: add (1<<(SHIFT-1)) when SHIFT > 0, then arithmetic shift right by SHIFT.
- Saturate: below 0 -> 0; above 2^PIXEL_W-1 -> 2^PIXEL_W-1. Result is registered into the m_* outputs.
- Latency: an accepted beat appears at m_tvalid_o exactly 3 cycles later when en stays high.
- Stall: stages hold while en is low; bubbles propagate when enabled.
- No beat is lost or duplicated. m_* outputs remain stable while m_tvalid_o && !m_tready_i.
- Position tagging: col and row are captured at S1 acceptance and travel with the beat.
  - tuser = (col==0 && row==0).
  - tlast = (col==IMG_W-1).
  - col increments on each accepted beat and wraps at IMG_W-1, incrementing row.
  - row wraps at IMG_H-1 to 0.
- s_tuser_i=1 on an accepted beat forces that beat's position to (0,0); counters continue from (1,0). It has no effect if the counters are already at (0,0).
- Reset mid-frame: in-flight beats are discarded and counters return to 0; the next accepted beat is tagged SOF.
- Simultaneous m_tready_i and a new input: the pipeline shifts, so throughput is 1 beat per cycle.

Optional Feature:
- Macro: CONV_KERNEL_MAC_STATS_EN
- When defined, adds output port sat_cnt_o (16 bits). It counts beats that clamped at either limit, incremented at the S3 to output transfer. It clears when a beat with tuser leaves S3 (that beat counts into the new frame) and saturates at 16'hFFFF.
- When undefined, the port and counter are absent and the datapath is identical.

Decomposition:
- conv_pkg additions:
  - coeff_t (signed COEFF_W)
  - coeff_kernel_t (coeff_t [24:0])
  - prod_t
  - acc_t
  - function sat_pixel (acc_t -> pixel_t)
- Sub-module conv_kernel_mac_round: combinational round/shift/saturate, output flopped in the parent. It is reusable by other filter blocks.

Test Plan:
- Identity: coeff centre=16, others 0, SHIFT=4; 128 ramp kernels with centre = beat index mod 256 -> output equals centre pixel, 3-cycle latency, 1 beat/cycle.
- Saturate high: all coeff=1, all pixels=255, SHIFT=0 -> sum 6375 -> output 255; with stats, sat_cnt_o increments per beat.
- Saturate low: centre coeff=-16, pixel 100 -> output 0. Rounding: centre coeff=3, pixel 5, SHIFT=1 -> (15+1)>>1 = 8.
- Backpressure: m_tready_i low for 5 cycles mid-stream with continuous input -> s_tready_o low, outputs held stable, and the full output sequence matches the reference model with no loss or duplicates.
- Framing: 2 frames of 16x8 beats -> m_tlast_o on every 16th beat; m_tuser_o on beats 0 and 128 only. An s_tuser_i pulse at beat 40 -> beat 40 tagged tuser and counting restarts from it.
- Reset: assert arst_n low with 2 beats in flight -> m_tvalid_o=0 immediately. The first post-reset output carries tuser=1.
